mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised synchronous modulo up/down counter; next generation of the team's 4-bit ripple counter.
- All bits share one clock, so there is no ripple skew.
- Adds direction control, parallel load, synchronous clear, programmable modulus, a wrap/saturate mode and a cascade-ready terminal-count output.
- Used as a building block for timers, dividers and multi-digit cascades, e.g. BCD stages chained through tc.

Parameters:
- WIDTH, 4: counter width in bits; must be 1 or greater.
- MODULO, 16: count range is 0..MODULO-1; must satisfy 2 <= MODULO <= 2**WIDTH.
- SATURATE, 0: 0 = wrap at bounds; 1 = hold at bounds.
- PRESCALE, 4: enabled cycles per count step; used only when COUNTER_PRESCALE_EN is defined; must be 1 or greater.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- d  in  WIDTH  load value.
- en  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down.
- q  out  WIDTH  current count (registered).
- tc  out  1  terminal count; combinational cascade output.
- wrap  out  1  one-cycle registered pulse when a wrap occurs.
- sat  out  1  registered; high while held at a bound in saturate mode.

Behaviour:
- Reset:
  - rst asserted sets q=0, wrap=0, sat=0 immediately, independent of clk.
  - The prescaler (when present) also clears.
  - Deassertion is sampled by clk; the first count occurs no earlier than the first rising edge after deassertion.
- Priority each rising edge: clr > load > en.
- clr=1: q<=0, wrap<=0, sat<=0.
- load=1 (clr=0):
  - q<=d if d < MODULO, otherwise q<=MODULO-1.
  - wrap<=0, sat<=0.
  - en is ignored that cycle.
- Step condition: step = en (macro absent) or en & prescale_tick (macro present).
- Step with up=1:
  - If q==MODULO-1:
    - SATURATE=0: q<=0, wrap<=1.
    - SATURATE=1: q holds, sat<=1.
  - Otherwise: q<=q+1, sat<=0.
- Step with up=0:
  - If q==0:
    - SATURATE=0: q<=MODULO-1, wrap<=1.
    - SATURATE=1: q holds, sat<=1.
  - Otherwise: q<=q-1, sat<=0.
- No step: q holds; wrap<=0; sat holds.
- wrap is high for exactly one cycle per wrap event. Consecutive wraps (e.g. MODULO=2) produce consecutive pulses.
- tc = step & (up ? q==MODULO-1 : q==0).
  - Zero latency, combinational.
  - Cascade rule: stage N+1 en driven by stage N tc.
  - Asserted in saturate mode as well.
- A direction change takes effect on the same edge; there is no dead cycle.
- Arithmetic is performed in WIDTH bits, with the comparison against MODULO-1. When MODULO=2**WIDTH, natural overflow is equivalent to a wrap.
- Prescaler:
  - Internal counter 0..PRESCALE-1 that advances only when en=1.
  - prescale_tick is high when the prescaler is at PRESCALE-1 and en=1.
  - clr and load reset the prescaler to 0.
  - en=0 freezes the prescaler.

Optional Feature:
- COUNTER_PRESCALE_EN defined:
  - Instantiates the prescaler sub-module.
  - q steps once per PRESCALE enabled cycles.
  - tc and wrap are qualified by prescale_tick.
- COUNTER_PRESCALE_EN undefined:
  - No prescaler logic; PRESCALE is ignored.
  - q steps on every enabled cycle.

Decomposition:
- Package counter_pkg:
  - Direction constants DIR_UP=1, DIR_DN=0.
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - Function clog2 for sizing the prescaler width.
- Sub-module cnt_prescaler, instantiated only under the macro:
  - Parameter: PRESCALE.
  - Ports: clk, rst, clr, en, tick.
- Top level holds the priority mux, bound compares and output flops.

Test Plan:
- Async reset: WIDTH=4, MODULO=10. Count to q=7, then pulse rst mid-cycle -> q=0, wrap=0, sat=0 before the next edge; counting resumes 0,1,2 after release.
- Up wrap: MODULO=10, en=1, up=1 from 0 -> q sequence 0..9,0; tc=1 only at q=9; wrap=1 exactly on the cycle q shows 0.
- Down and saturate: SATURATE=1, load d=2, up=0, en=1 -> q=2,1,0,0,0; sat=1 from the second 0 onward; wrap never asserted; tc=1 while q=0.
- Priority and clamp: clr=1, load=1, d=5 in the same cycle -> q=0. Then load d=13 with MODULO=10 -> q=9. Then load=1, en=1, d=3 -> q=3 with no step.
- Cascade: two MODULO=10 instances, second en driven by first tc, 100 enabled cycles -> {hi,lo} runs 00..99; both wrap after cycle 100.
- Prescale (macro on, PRESCALE=4): en=1 for 12 cycles -> q=3; en low for 2 cycles mid-way -> q frozen and prescaler frozen.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
// Optional prescaler is enabled by defining COUNTER_PRESCALE_EN.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Ceiling log2, used to size the prescaler count register.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable-gated prescaler: ticks once every PRESCALE enabled cycles.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module cnt_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW =
    (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = en & (cnt_q == LAST);

  // Advance only on enabled cycles; clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous modulo up/down counter with load, clear and cascade tc.
// Define COUNTER_PRESCALE_EN to gate count steps through cnt_prescaler.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULO);

  logic             tick;
  logic             step;
  logic             at_top;
  logic             at_bot;
  logic             at_bound;
  logic [WIDTH-1:0] d_clamp;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             sat_q;
  logic             sat_d;

`ifdef COUNTER_PRESCALE_EN
  logic pre_clr;

  assign pre_clr = clr | load;

  cnt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .clr (pre_clr),
    .en  (en),
    .tick(tick)
  );
`else
  // No prescaler: every enabled cycle steps (PRESCALE must be >= 1).
  assign tick = (PRESCALE > 0);
`endif

  assign step     = en & tick;
  assign at_top   = (q_q == TOP);
  assign at_bot   = (q_q == '0);
  assign at_bound = (up == DIR_UP) ? at_top : at_bot;
  assign tc       = step & at_bound;

  // Out-of-range load values clamp to the top of the range.
  assign d_clamp = ({1'b0, d} < MODW) ? d : TOP;

  // Next state: clear beats load beats step.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    if (clr) begin
      q_d   = '0;
      sat_d = 1'b0;
    end else if (load) begin
      q_d   = d_clamp;
      sat_d = 1'b0;
    end else if (step) begin
      if (at_bound) begin
        if (SATURATE == MODE_SAT) begin
          sat_d = 1'b1;
        end else begin
          q_d    = (up == DIR_UP) ? '0 : TOP;
          wrap_d = 1'b1;
        end
      end else begin
        q_d   = (up == DIR_UP) ? q_q + WIDTH'(1)
                               : q_q - WIDTH'(1);
        sat_d = 1'b0;
      end
    end
  end

  // Count and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (wrap, saturate, cascade).
// Prescale section is active when COUNTER_PRESCALE_EN is defined.
module tb_mod_updown_counter;

  localparam int PRE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic [3:0] d = 4'd0;

  logic [3:0] q_a, q_s;
  logic [2:0] q_p;
  logic       tc_a, tc_s, tc_p;
  logic       w_a, w_s, w_p;
  logic       s_a, s_s, s_p;

  logic       c_en = 1'b0;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, w_lo, w_hi, s_lo, s_hi;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0),
    .PRESCALE(PRE)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d),
    .en(en), .up(up), .q(q_a), .tc(tc_a), .wrap(w_a), .sat(s_a));

  mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1),
    .PRESCALE(PRE)) u_s (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d),
    .en(en), .up(up), .q(q_s), .tc(tc_s), .wrap(w_s), .sat(s_s));

  mod_updown_counter #(.WIDTH(3), .MODULO(8), .SATURATE(0),
    .PRESCALE(PRE)) u_p (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d[2:0]),
    .en(en), .up(up), .q(q_p), .tc(tc_p), .wrap(w_p), .sat(s_p));

  mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0),
    .PRESCALE(PRE)) u_lo (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .d(4'd0),
    .en(c_en), .up(1'b1), .q(q_lo), .tc(tc_lo), .wrap(w_lo),
    .sat(s_lo));

  mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0),
    .PRESCALE(PRE)) u_hi (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .d(4'd0),
    .en(tc_lo), .up(1'b1), .q(q_hi), .tc(tc_hi), .wrap(w_hi),
    .sat(s_hi));

  int checks = 0;
  int failures = 0;

  typedef struct {
    int q;
    bit w;
    bit s;
    int pre;
  } ms_t;

  ms_t ma, ms, mp;

  typedef struct {
    bit         c;
    bit         l;
    logic [3:0] dv;
    bit         e;
    bit         u;
    int         qa;
    int         wa;
    int         tca;
    int         qs;
    int         ss;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit mstep(ms_t s, bit e);
`ifdef COUNTER_PRESCALE_EN
    return e && (s.pre == PRE - 1);
`else
    return e;
`endif
  endfunction

  function automatic bit mtc(ms_t s, int m, bit e, bit u);
    if (!mstep(s, e)) return 1'b0;
    return u ? (s.q == m - 1) : (s.q == 0);
  endfunction

  function automatic ms_t mnext(ms_t s, int m, bit satm, bit c,
                                bit l, int dv, bit e, bit u);
    ms_t n;
    bit  stp;
    n = s;
    n.w = 1'b0;
    stp = mstep(s, e);
    if (c) begin
      n.q = 0; n.s = 1'b0; n.pre = 0;
    end else if (l) begin
      n.q = (dv < m) ? dv : m - 1;
      n.s = 1'b0; n.pre = 0;
    end else begin
      if (e) n.pre = (s.pre + 1) % PRE;
      if (stp) begin
        if ((u && s.q == m - 1) || (!u && s.q == 0)) begin
          if (satm) n.s = 1'b1;
          else begin
            n.q = u ? 0 : m - 1;
            n.w = 1'b1;
          end
        end else begin
          n.q = u ? s.q + 1 : s.q - 1;
          n.s = 1'b0;
        end
      end
    end
    return n;
  endfunction

  task automatic drive(bit c, bit l, logic [3:0] dv, bit e, bit u);
    @(negedge clk);
    clr = c; load = l; d = dv; en = e; up = u;
    #1;
  endtask

  task automatic adv();
    ma = mnext(ma, 10, 1'b0, clr, load, int'(d), en, up);
    ms = mnext(ms, 10, 1'b1, clr, load, int'(d), en, up);
    mp = mnext(mp, 8, 1'b0, clr, load, int'(d[2:0]), en, up);
    @(posedge clk);
    #1;
  endtask

  task automatic tccheck(string tag);
    chk({tag, " tc_a"}, int'(tc_a), int'(mtc(ma, 10, en, up)));
    chk({tag, " tc_s"}, int'(tc_s), int'(mtc(ms, 10, en, up)));
    chk({tag, " tc_p"}, int'(tc_p), int'(mtc(mp, 8, en, up)));
  endtask

  task automatic mcheck(string tag);
    chk({tag, " q_a"}, int'(q_a), ma.q);
    chk({tag, " w_a"}, int'(w_a), int'(ma.w));
    chk({tag, " s_a"}, int'(s_a), int'(ma.s));
    chk({tag, " q_s"}, int'(q_s), ms.q);
    chk({tag, " w_s"}, int'(w_s), int'(ms.w));
    chk({tag, " s_s"}, int'(s_s), int'(ms.s));
    chk({tag, " q_p"}, int'(q_p), mp.q);
    chk({tag, " w_p"}, int'(w_p), int'(mp.w));
    chk({tag, " s_p"}, int'(s_p), int'(mp.s));
  endtask

  task automatic cyc(string tag, bit c, bit l, logic [3:0] dv,
                     bit e, bit u);
    drive(c, l, dv, e, u);
    tccheck(tag);
    adv();
    mcheck(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ma = '{0, 1'b0, 1'b0, 0};
    ms = '{0, 1'b0, 1'b0, 0};
    mp = '{0, 1'b0, 1'b0, 0};

    tbl[0]  = '{1'b1, 1'b1, 4'd5,  1'b1, 1'b1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 4'd13, 1'b0, 1'b1, 9, 0, 0, 9, 0};
    tbl[2]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 0, 1, 1, 9, 1};
    tbl[3]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1, 0, 0, 9, 1};
    tbl[4]  = '{1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 3, 0, 0, 3, 0};
    tbl[5]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 2, 0, 0, 2, 0};
    tbl[6]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1, 0, 0, 1, 0};
    tbl[7]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 9, 1, 1, 0, 1};
    tbl[9]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 9, 0, 0, 0, 1};
    tbl[10] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 0, 1, 1, 1, 0};
    tbl[11] = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b1, 9, 0, 0, 9, 0};
    tbl[12] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 8, 0, 0, 8, 0};
    tbl[13] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 0, 0, 0, 0, 0};
    tbl[14] = '{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 9, 0, 0, 9, 0};

    // Reset state while rst is held.
    #1;
    chk("rst q_a", int'(q_a), 0);
    chk("rst w_a", int'(w_a), 0);
    chk("rst s_a", int'(s_a), 0);
    chk("rst q_s", int'(q_s), 0);
    chk("rst s_s", int'(s_s), 0);
    chk("rst q_lo", int'(q_lo), 0);
    @(negedge clk);
    rst = 1'b0;

`ifndef COUNTER_PRESCALE_EN
    // Table-driven vectors on the wrap and saturate instances.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].c, tbl[i].l, tbl[i].dv, tbl[i].e, tbl[i].u);
      chk($sformatf("tbl%0d tc_a", i), int'(tc_a), tbl[i].tca);
      adv();
      chk($sformatf("tbl%0d q_a", i), int'(q_a), tbl[i].qa);
      chk($sformatf("tbl%0d w_a", i), int'(w_a), tbl[i].wa);
      chk($sformatf("tbl%0d q_s", i), int'(q_s), tbl[i].qs);
      chk($sformatf("tbl%0d s_s", i), int'(s_s), tbl[i].ss);
      chk($sformatf("tbl%0d w_s", i), int'(w_s), 0);
    end

    // Up count through a full wrap.
    cyc("upclr", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      chk($sformatf("up%0d tc_a", i), int'(tc_a), int'(i == 10));
      adv();
      chk($sformatf("up%0d q_a", i), int'(q_a), i % 10);
      chk($sformatf("up%0d w_a", i), int'(w_a), int'(i == 10));
    end

    // Down into the lower bound in saturate mode.
    cyc("ld2", 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    chk("ld2 q_s", int'(q_s), 2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      chk($sformatf("dn%0d tc_s", i), int'(tc_s), int'(i >= 2));
      adv();
      chk($sformatf("dn%0d q_s", i), int'(q_s), (i == 0) ? 1 : 0);
      chk($sformatf("dn%0d s_s", i), int'(s_s), int'(i >= 2));
      chk($sformatf("dn%0d w_s", i), int'(w_s), 0);
    end

    // Two-digit cascade 00..99 then wrap of both digits.
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      c_en = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("cas%0d val", i),
          int'(q_hi) * 10 + int'(q_lo), i % 100);
      chk($sformatf("cas%0d w_hi", i), int'(w_hi), int'(i == 100));
      chk($sformatf("cas%0d w_lo", i), int'(w_lo),
          int'(i % 10 == 0));
    end
    @(negedge clk);
    c_en = 1'b0;
`else
    // Prescaled stepping with a two-cycle enable gap.
    cyc("pclr", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      cyc($sformatf("pre%0d", i), 1'b0, 1'b0, 4'd0,
          !(i == 6 || i == 7), 1'b1);
      if (i == 7) chk("pre frozen q_a", int'(q_a), 1);
    end
    chk("pre12 q_a", int'(q_a), 3);
`endif

    // Count to 7, then assert rst mid-cycle.
    begin
      int n;
      n = 0;
      cyc("r7clr", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      while (ma.q != 7 && n < 100) begin
        cyc("r7", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        n++;
      end
      chk("reach7 q_a", int'(q_a), 7);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    en = 1'b0;
    #1;
    chk("arst q_a", int'(q_a), 0);
    chk("arst w_a", int'(w_a), 0);
    chk("arst s_a", int'(s_a), 0);
    chk("arst q_s", int'(q_s), 0);
    chk("arst q_p", int'(q_p), 0);
    ma = '{0, 1'b0, 1'b0, 0};
    ms = '{0, 1'b0, 1'b0, 0};
    mp = '{0, 1'b0, 1'b0, 0};
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      cyc($sformatf("resume%0d", i), 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
`ifndef COUNTER_PRESCALE_EN
      chk($sformatf("resume%0d q_a", i), int'(q_a), i);
`endif
    end

    // Randomised traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      cyc($sformatf("rnd%0d", i),
          ($urandom % 20) == 0,
          ($urandom % 12) == 0,
          4'($urandom % 16),
          ($urandom % 4) != 0,
          1'($urandom % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
